// File: rtl/vga_win_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_win_timing
// Brief    : Parametrised VGA timing generator with a movable, 2^S-scaled
//            image window and incremental frame-buffer read address.
// Revision : 1.0 - initial release
// ============================================================================
module vga_win_timing #(
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int WIN_W       = 200,
    parameter int WIN_H       = 200,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [10:0]       win_x,
    input  logic [10:0]       win_y,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic              win_flag,
    output logic [ADDR_W-1:0] addr,
    output logic              frame_start
);

    localparam int c_H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int c_V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int c_H_BEG = H_SYNC + H_BP;
    localparam int c_V_BEG = V_SYNC + V_BP;
    localparam int c_H_END = c_H_BEG + H_ACTIVE;
    localparam int c_V_END = c_V_BEG + V_ACTIVE;

    localparam logic signed [15:0] c_H_OFF    = 16'(c_H_BEG);
    localparam logic signed [15:0] c_V_OFF    = 16'(c_V_BEG);
    localparam logic signed [15:0] c_WIN_WS   = 16'(WIN_W << SCALE_SHIFT);
    localparam logic signed [15:0] c_WIN_HS   = 16'(WIN_H << SCALE_SHIFT);
    localparam logic signed [15:0] c_SUB_MASK = 16'((1 << SCALE_SHIFT) - 1);

    logic [11:0]       r_h_cnt;
    logic [11:0]       r_v_cnt;
    logic [10:0]       r_ox;
    logic [10:0]       r_oy;
    logic [11:0]       r_col;
    logic [ADDR_W-1:0] r_row_base;

    logic              w_h_end;
    logic              w_v_end;
    logic [11:0]       w_h_next;
    logic [11:0]       w_v_next;
    logic signed [15:0] w_wx;
    logic signed [15:0] w_wy;
    logic signed [15:0] w_wx_next;
    logic signed [15:0] w_wy_next;
    logic              w_de;
    logic              w_flag;
    logic              w_frame_start;
    logic [ADDR_W-1:0] w_addr;

    assign w_h_end  = (r_h_cnt == 12'(c_H_TOT - 1));
    assign w_v_end  = (r_v_cnt == 12'(c_V_TOT - 1));
    assign w_h_next = w_h_end ? 12'd0 : r_h_cnt + 12'd1;
    assign w_v_next = w_h_end ? (w_v_end ? 12'd0 : r_v_cnt + 12'd1) : r_v_cnt;

    // Window-relative coordinates; negative means left of / above the window.
    assign w_wx      = $signed({4'b0000, r_h_cnt})  - c_H_OFF - $signed({5'b00000, r_ox});
    assign w_wy      = $signed({4'b0000, r_v_cnt})  - c_V_OFF - $signed({5'b00000, r_oy});
    assign w_wx_next = $signed({4'b0000, w_h_next}) - c_H_OFF - $signed({5'b00000, r_ox});
    assign w_wy_next = $signed({4'b0000, w_v_next}) - c_V_OFF - $signed({5'b00000, r_oy});

    assign w_de = (r_h_cnt >= 12'(c_H_BEG)) && (r_h_cnt < 12'(c_H_END)) &&
                  (r_v_cnt >= 12'(c_V_BEG)) && (r_v_cnt < 12'(c_V_END));

    assign w_flag = w_de &&
                    (w_wx >= 16'sd0) && (w_wx < c_WIN_WS) &&
                    (w_wy >= 16'sd0) && (w_wy < c_WIN_HS);

    assign w_frame_start = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
    assign w_addr        = r_row_base + ADDR_W'(r_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_col       <= '0;
            r_row_base  <= '0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            win_flag    <= 1'b0;
            addr        <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_col       <= '0;
            r_row_base  <= '0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            win_flag    <= 1'b0;
            addr        <= '0;
            frame_start <= 1'b0;
        end else begin
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;

            if (w_frame_start) begin
                r_ox <= win_x;
                r_oy <= win_y;
            end

            // Column index tracks wx>>S for the pixel about to be decoded.
            if (w_wx_next <= 16'sd0) begin
                r_col <= '0;
            end else if ((w_wx_next & c_SUB_MASK) == 16'sd0) begin
                r_col <= r_col + 12'd1;
            end

            // Row base tracks (wy>>S)*WIN_W for the line about to start.
            if (w_h_end) begin
                if (w_wy_next <= 16'sd0) begin
                    r_row_base <= '0;
                end else if (((w_wy_next & c_SUB_MASK) == 16'sd0) && (w_wy_next < c_WIN_HS)) begin
                    r_row_base <= r_row_base + ADDR_W'(WIN_W);
                end
            end

            hs          <= (r_h_cnt < 12'(H_SYNC)) ? HS_POL : ~HS_POL;
            vs          <= (r_v_cnt < 12'(V_SYNC)) ? VS_POL : ~VS_POL;
            de          <= w_de;
            win_flag    <= w_flag;
            addr        <= w_flag ? w_addr : '0;
            frame_start <= w_frame_start;
        end
    end

endmodule
`default_nettype wire
